// File: rtl/leaf_rr_scheduler_pkg.sv
// Shared types and helpers for the leaf-instance schedulers.
// Holds the scheduler FSM encoding, index-width helper and statistics counter width.
package leaf_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_e;

  localparam int STAT_W = 16;

  // An index into n slots needs at least one bit even when n is 1.
  function automatic int idx_w(input int n);
    if ($clog2(n) < 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/leaf_rr_scheduler_pick.sv
// leaf_rr_pick: combinational rotating-priority picker.
// Returns the first set request at or above i_ptr, wrapping modulo N.
module leaf_rr_pick
  import leaf_sched_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_j;
  logic          w_hit;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    w_hit   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j     = IW'((int'(i_ptr) + k) % N);
      w_hit   = i_req[w_j];
      o_found = o_found | w_hit;
      o_idx   = w_hit ? w_j : o_idx;
    end
  end

endmodule

// File: rtl/leaf_rr_scheduler.sv
// leaf_rr_scheduler: round-robin burst scheduler sharing one leaf datapath among N_REQ requesters.
// Optional per-requester completed-burst counters when LEAF_RR_SCHEDULER_STATS_EN is defined.
module leaf_rr_scheduler
  import leaf_sched_pkg::*;
#(
  parameter int N_REQ     = 5,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [idx_w(N_REQ)-1:0]   out_src,
  input  logic                      out_ready,
  output logic                      busy
`ifdef LEAF_RR_SCHEDULER_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [N_REQ*STAT_W-1:0]   grant_cnt
`endif
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     w_ptr_nxt;
  logic [IW-1:0]     r_grant;
  logic [IW-1:0]     w_grant_nxt;
  logic [CW-1:0]     r_beat_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_found;
  logic [IW-1:0]     w_pick;
  logic [IW-1:0]     w_ptr_inc;
  logic              w_acc;
  logic              w_done;
  logic [DATA_W-1:0] w_data [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_data[g] = req_data[g*DATA_W +: DATA_W];
  end

  leaf_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_ptr_inc = (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + IW'(1);
  assign w_acc     = out_valid && out_ready;
  assign w_done    = w_acc && out_last;

  // Zero-latency pass-through of the granted requester while transferring.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_src   = '0;
    busy      = 1'b0;
    case (r_state)
      XFER: begin
        busy               = 1'b1;
        out_valid          = req_valid[r_grant];
        out_data           = w_data[r_grant];
        out_src            = r_grant;
        req_ready[r_grant] = out_ready;
        out_last           = req_last[r_grant] | (r_beat_cnt == CW'(MAX_BURST - 1));
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Next-state: arbitrate in IDLE, count beats and release on the last one in XFER.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = XFER;
          w_grant_nxt = w_pick;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      XFER: begin
        if (w_done) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_ptr_inc;
          w_cnt_nxt   = '0;
        end else if (w_acc) begin
          w_cnt_nxt = r_beat_cnt + CW'(1);
        end else begin
          w_cnt_nxt = r_beat_cnt;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

`ifdef LEAF_RR_SCHEDULER_STATS_EN
  logic [STAT_W-1:0] r_stat [N_REQ];

  // Saturating completed-burst counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_stat[i] <= '0;
      end
    end else if (stats_clr) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_stat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_done && (r_grant == IW'(i)) && (r_stat[i] != {STAT_W{1'b1}})) begin
          r_stat[i] <= r_stat[i] + STAT_W'(1);
        end else begin
          r_stat[i] <= r_stat[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign grant_cnt[g*STAT_W +: STAT_W] = r_stat[g];
  end
`endif

endmodule

// File: tb/tb_leaf_rr_scheduler.sv
// Self-checking bench for leaf_rr_scheduler: queue-based requesters, an ownership-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_leaf_rr_scheduler;

  localparam int N     = 5;
  localparam int DW    = 16;
  localparam int MB    = 4;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic            busy;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_src;
`ifdef LEAF_RR_SCHEDULER_STATS_EN
  logic            stats_clr;
  logic [N*16-1:0] grant_cnt;
  int              gcnt [N];
  bit              clr_arm;
  bit              rnd_clr;
`endif

  always #5 clk = ~clk;

  leaf_rr_scheduler #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef LEAF_RR_SCHEDULER_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  // Requester beat queues: {last, data}
  logic [DW:0] mem [N][DEPTH];
  int          head [N];
  int          tail [N];
  bit          vhold [N];
  // Reference model: current owner (-1 = none), rotation pointer, beats taken this grant
  int          m_owner, m_ptr, m_beats;
  int          vpct, rpct, rforce;
  int          checks, failures, cyc;
  int          log_src [$];
  bit          log_last [$];
  int          log_cyc [$];
  logic [DW-1:0] s_data;
  logic [N-1:0]  s_ready;
  logic          s_valid;
  logic [2:0]    s_src;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] d, input bit l);
    mem[i][tail[i] % DEPTH] = {l, d};
    tail[i]++;
  endtask

  task automatic cycle();
    logic [N-1:0]  e_ready;
    logic          e_valid, e_last, acc;
    logic [DW-1:0] e_data;
    int            o;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (head[i] != tail[i]) && (vhold[i] || ($urandom_range(99) < vpct));
      if (req_valid[i]) begin
        {req_last[i], req_data[i*DW +: DW]} = mem[i][head[i] % DEPTH];
      end else begin
        req_last[i]          = 1'($urandom_range(1));
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
    out_ready = (rforce >= 0) ? 1'(rforce) : ($urandom_range(99) < rpct);
    o = m_owner;
    e_ready = '0;
    if (o >= 0) begin
      e_valid    = req_valid[o];
      e_data     = req_data[o*DW +: DW];
      e_last     = req_last[o] || (m_beats == MB - 1);
      e_ready[o] = out_ready;
    end else begin
      e_valid = 1'b0;
      e_data  = '0;
      e_last  = 1'b0;
    end
    acc = (o >= 0) && e_valid && out_ready;
`ifdef LEAF_RR_SCHEDULER_STATS_EN
    stats_clr = (clr_arm && acc && e_last) || (rnd_clr && ($urandom_range(199) == 0));
`endif
    @(negedge clk);
    chk("out_valid", 80'(out_valid), 80'(e_valid));
    chk("out_data", 80'(out_data), 80'(e_data));
    chk("out_last", 80'(out_last), 80'(e_last));
    chk("out_src", 80'(out_src), (o >= 0) ? 80'(o) : 80'(0));
    chk("req_ready", 80'(req_ready), 80'(e_ready));
    chk("busy", 80'(busy), 80'(o >= 0));
`ifdef LEAF_RR_SCHEDULER_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", 80'(grant_cnt[i*16 +: 16]), 80'(gcnt[i]));
`endif
    s_data  = out_data;
    s_ready = req_ready;
    s_valid = out_valid;
    s_src   = out_src;
    @(posedge clk);
    cyc++;
    if (o < 0) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          break;
        end
      end
      m_beats = 0;
    end else if (acc) begin
      head[o]++;
      log_src.push_back(o);
      log_last.push_back(e_last);
      log_cyc.push_back(cyc);
      if (e_last) begin
        m_owner = -1;
        m_ptr   = (o + 1) % N;
        m_beats = 0;
      end else begin
        m_beats++;
      end
    end
`ifdef LEAF_RR_SCHEDULER_STATS_EN
    if (stats_clr) begin
      for (int i = 0; i < N; i++) gcnt[i] = 0;
    end else if (acc && e_last && gcnt[o] < 65535) begin
      gcnt[o]++;
    end
`endif
    for (int i = 0; i < N; i++) vhold[i] = req_valid[i] && !(acc && i == o);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst_n   = 1'b0;
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    for (int i = 0; i < N; i++) vhold[i] = 1'b0;
`ifdef LEAF_RR_SCHEDULER_STATS_EN
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    stats_clr = 1'b0;
`endif
    repeat (n) begin
      @(negedge clk);
      chk("rst_out_valid", 80'(out_valid), 80'(0));
      chk("rst_out_data", 80'(out_data), 80'(0));
      chk("rst_out_last", 80'(out_last), 80'(0));
      chk("rst_out_src", 80'(out_src), 80'(0));
      chk("rst_req_ready", 80'(req_ready), 80'(0));
      chk("rst_busy", 80'(busy), 80'(0));
`ifdef LEAF_RR_SCHEDULER_STATS_EN
      chk("rst_grant_cnt", 80'(grant_cnt), 80'(0));
`endif
      @(posedge clk);
      cyc++;
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic run_until(input int nlog, input int budget, input string nm);
    int b;
    b = 0;
    while (log_src.size() < nlog && b < budget) begin
      cycle();
      b++;
    end
    chk(nm, 80'(log_src.size() >= nlog), 80'(1));
  endtask

  task automatic flush_queues();
    for (int i = 0; i < N; i++) head[i] = tail[i];
    req_valid = '0;
    log_src.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  initial begin
    int exp2 [6];
    int exp3s [9];
    bit exp3l [9];
    int base;
    exp2  = '{0, 1, 2, 3, 4, 0};
    exp3s = '{2, 2, 2, 2, 3, 4, 2, 2, 2};
    exp3l = '{0, 0, 0, 1, 1, 1, 0, 0, 1};
    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
    vpct = 100; rpct = 100; rforce = 1;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
`ifdef LEAF_RR_SCHEDULER_STATS_EN
    stats_clr = 1'b0; clr_arm = 1'b0; rnd_clr = 1'b0;
`endif
    #2;

    // 1: reset with no requests, then idle
    apply_reset(3);
    repeat (3) cycle();
    chk("idle_busy", 80'(s_valid), 80'(0));

    // 2: one single-beat burst per requester, requester 0 has a second
    apply_reset(1);
    flush_queues();
    for (int i = 0; i < N; i++) push(i, DW'(16'hA000 + i), 1'b1);
    push(0, 16'hA100, 1'b1);
    run_until(6, 40, "rr_timeout");
    for (int k = 0; k < 6 && k < log_src.size(); k++) chk("rr_order", 80'(log_src[k]), 80'(exp2[k]));
    for (int k = 0; k < 5 && k + 1 < log_cyc.size(); k++) chk("rr_gap", 80'(log_cyc[k+1] - log_cyc[k]), 80'(2));

    // 3: 7-beat burst from requester 2 splits at MAX_BURST; 3 and 4 go in between
    apply_reset(1);
    flush_queues();
    for (int k = 1; k <= 7; k++) push(2, DW'(16'h2000 + k), k == 7);
    push(3, 16'h3001, 1'b1);
    push(4, 16'h4001, 1'b1);
    run_until(9, 60, "split_timeout");
    for (int k = 0; k < 9 && k < log_src.size(); k++) begin
      chk("split_src", 80'(log_src[k]), 80'(exp3s[k]));
      chk("split_last", 80'(log_last[k]), 80'(exp3l[k]));
    end

    // 4: backpressure mid-burst
    apply_reset(1);
    flush_queues();
    for (int k = 1; k <= 3; k++) push(1, DW'(16'h1000 + k), k == 3);
    cycle();
    cycle();
    rforce = 0;
    repeat (5) begin
      cycle();
      chk("bp_valid", 80'(s_valid), 80'(1));
      chk("bp_data", 80'(s_data), 80'(16'h1002));
      chk("bp_src", 80'(s_src), 80'(1));
      chk("bp_ready", 80'(s_ready), 80'(0));
    end
    rforce = 1;
    cycle();
    chk("bp_accepted", 80'(log_src.size()), 80'(2));
    cycle();
    chk("bp_last", 80'(log_last[log_last.size()-1]), 80'(1));

    // 5: reset mid-burst restores rr_ptr to 0
    apply_reset(1);
    flush_queues();
    push(3, 16'h3100, 1'b1);
    run_until(1, 10, "mr_first_timeout");
    for (int k = 1; k <= 4; k++) push(1, DW'(16'h1100 + k), k == 4);
    run_until(3, 20, "mr_beats_timeout");
    head[1] = tail[1];
    req_valid = '0;
    apply_reset(1);
    push(3, 16'h3200, 1'b1);
    push(4, 16'h4200, 1'b1);
    run_until(4, 10, "mr_after_timeout");
    if (log_src.size() >= 4) chk("mr_ptr_reset", 80'(log_src[3]), 80'(3));

`ifdef LEAF_RR_SCHEDULER_STATS_EN
    // 6: completed-burst counter and clear priority
    apply_reset(1);
    flush_queues();
    for (int k = 0; k < 3; k++) push(1, DW'(16'h6000 + k), 1'b1);
    run_until(3, 30, "stat_timeout");
    chk("stat_three", 80'(grant_cnt[16 +: 16]), 80'(3));
    clr_arm = 1'b1;
    push(1, 16'h6003, 1'b1);
    run_until(4, 10, "stat_clr_timeout");
    chk("stat_clr", 80'(grant_cnt[16 +: 16]), 80'(0));
    clr_arm = 1'b0;
    rnd_clr = 1'b1;
`endif

    // Random traffic against the model
    apply_reset(2);
    flush_queues();
    rforce = -1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        vpct = $urandom_range(100, 30);
        rpct = $urandom_range(100, 20);
      end
      for (int i = 0; i < N; i++) begin
        if (head[i] == tail[i] && $urandom_range(99) < 15) begin
          base = $urandom_range(7, 1);
          for (int k = 1; k <= base; k++) push(i, DW'($urandom), (k == base) && ($urandom_range(9) != 0));
        end
      end
      if (c == 2000) apply_reset(1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
